// File: rtl/ldst_sequencer.sv
// Control-step sequencer for instruction fetch and the offset-addressed
// memory instructions ld, ldi and st. Moore FSM with registered outputs,
// bounded handshake stalls and a sticky fault report.
module ldst_sequencer #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           OPC_WIDTH  = 5,
   parameter logic [OPC_WIDTH-1:0]  OPC_LD     = OPC_WIDTH'(0),
   parameter logic [OPC_WIDTH-1:0]  OPC_LDI    = OPC_WIDTH'(1),
   parameter logic [OPC_WIDTH-1:0]  OPC_ST     = OPC_WIDTH'(2),
   parameter logic [5:0]            ALU_ADD    = 6'd4,
   parameter int unsigned           WAIT_LIMIT = 16
) (
   input  logic                  Clock,
   input  logic                  clear,
   input  logic                  run,
   input  logic [DATA_WIDTH-1:0] ir,
   input  logic                  memFinished,
   input  logic                  aluFinished,
   output logic                  PCout,
   output logic                  IncPC,
   output logic                  MARin,
   output logic                  Read,
   output logic                  Write,
   output logic                  MDRin,
   output logic                  MDRout,
   output logic                  IRin,
   output logic                  Gra,
   output logic                  Grb,
   output logic                  Rout,
   output logic                  Rin,
   output logic                  BAout,
   output logic                  RYin,
   output logic                  Immout,
   output logic                  RZin,
   output logic                  RZLOout,
   output logic                  aluStart,
   output logic [5:0]            opSelect,
   output logic [3:0]            step,
   output logic                  done,
   output logic                  fault,
   output logic [1:0]            faultCode
);

   localparam int unsigned CNT_W = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_T7    = 4'd8,
      S_DONE  = 4'd9,
      S_FAULT = 4'd15
   } state_t;

   typedef struct packed {
      logic pc_out, inc_pc, mar_in, read, write, mdr_in, mdr_out, ir_in;
      logic gra, grb, r_out, r_in, ba_out, ry_in, imm_out, rz_in, rzlo_out;
   } ctl_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [OPC_WIDTH-1:0]  opc_q, opc_d;
   logic [1:0]            fcode_q, fcode_d;
   ctl_t                  ctl_q, ctl_d;
   logic                  alu_start_q, alu_start_d;
   logic [5:0]            op_sel_q, op_sel_d;
   logic                  done_q, done_d;
   logic                  fault_q, fault_d;
   logic [OPC_WIDTH-1:0]  ir_opc;
   logic                  ir_legal;
   logic                  unused_ir_bits;

   assign ir_opc         = ir[DATA_WIDTH-1 -: OPC_WIDTH];
   assign ir_legal       = (ir_opc == OPC_LD) || (ir_opc == OPC_LDI) || (ir_opc == OPC_ST);
   assign unused_ir_bits = ^ir[DATA_WIDTH-OPC_WIDTH-1:0];

   // State, wait counter, latched opcode and all outputs
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         opc_q       <= '0;
         fcode_q     <= '0;
         ctl_q       <= '0;
         alu_start_q <= 1'b0;
         op_sel_q    <= '0;
         done_q      <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         opc_q       <= opc_d;
         fcode_q     <= fcode_d;
         ctl_q       <= ctl_d;
         alu_start_q <= alu_start_d;
         op_sel_q    <= op_sel_d;
         done_q      <= done_d;
         fault_q     <= fault_d;
      end
   end

   // Next state, then outputs decoded from the state being entered
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      opc_d       = opc_q;
      fcode_d     = fcode_q;
      ctl_d       = '0;
      alu_start_d = 1'b0;
      op_sel_d    = '0;
      done_d      = 1'b0;
      fault_d     = 1'b0;

      case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0: begin
            state_d = S_T1;
            cnt_d   = '0;
         end
         S_T1: begin
            if (memFinished)            state_d = S_T2;
            else if (cnt_q == CNT_LAST) begin state_d = S_FAULT; fcode_d = 2'b01; end
            else                        cnt_d = cnt_q + CNT_W'(1);
         end
         S_T2: state_d = S_T3;
         S_T3: begin
            opc_d = ir_opc;
            if (ir_legal) begin state_d = S_T4; cnt_d = '0; end
            else          begin state_d = S_FAULT; fcode_d = 2'b11; end
         end
         S_T4: begin
            if (aluFinished)            state_d = S_T5;
            else if (cnt_q == CNT_LAST) begin state_d = S_FAULT; fcode_d = 2'b10; end
            else                        cnt_d = cnt_q + CNT_W'(1);
         end
         S_T5: begin
            if (opc_q == OPC_LDI) state_d = S_DONE;
            else begin state_d = S_T6; cnt_d = '0; end
         end
         S_T6: begin
            if (opc_q != OPC_LD)        begin state_d = S_T7; cnt_d = '0; end
            else if (memFinished)       state_d = S_T7;
            else if (cnt_q == CNT_LAST) begin state_d = S_FAULT; fcode_d = 2'b01; end
            else                        cnt_d = cnt_q + CNT_W'(1);
         end
         S_T7: begin
            if (opc_q != OPC_ST)        state_d = S_DONE;
            else if (memFinished)       state_d = S_DONE;
            else if (cnt_q == CNT_LAST) begin state_d = S_FAULT; fcode_d = 2'b01; end
            else                        cnt_d = cnt_q + CNT_W'(1);
         end
         S_DONE:  state_d = run ? S_T0 : S_IDLE;
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_T0: ctl_d.inc_pc = 1'b1;
         S_T1: begin
            ctl_d.pc_out = 1'b1; ctl_d.mar_in = 1'b1;
            ctl_d.read   = 1'b1; ctl_d.mdr_in = 1'b1;
         end
         S_T2: begin ctl_d.mdr_out = 1'b1; ctl_d.ir_in = 1'b1; end
         S_T3: begin
            ctl_d.grb    = 1'b1; ctl_d.ba_out = 1'b1;
            ctl_d.r_out  = 1'b1; ctl_d.ry_in  = 1'b1;
         end
         S_T4: begin
            ctl_d.imm_out = 1'b1; ctl_d.rz_in = 1'b1;
            op_sel_d      = ALU_ADD;
            alu_start_d   = (state_q != S_T4);
         end
         S_T5: begin
            ctl_d.rzlo_out = 1'b1;
            op_sel_d       = ALU_ADD;
            if (opc_d == OPC_LDI) begin ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1; end
            else                   ctl_d.mar_in = 1'b1;
         end
         S_T6: begin
            ctl_d.mdr_in = 1'b1;
            if (opc_d == OPC_LD) ctl_d.read = 1'b1;
            else begin ctl_d.gra = 1'b1; ctl_d.r_out = 1'b1; end
         end
         S_T7: begin
            if (opc_d == OPC_ST) ctl_d.write = 1'b1;
            else begin ctl_d.mdr_out = 1'b1; ctl_d.gra = 1'b1; ctl_d.r_in = 1'b1; end
         end
         S_DONE:  done_d  = 1'b1;
         S_FAULT: fault_d = 1'b1;
         default: ;
      endcase
   end

   assign PCout     = ctl_q.pc_out;
   assign IncPC     = ctl_q.inc_pc;
   assign MARin     = ctl_q.mar_in;
   assign Read      = ctl_q.read;
   assign Write     = ctl_q.write;
   assign MDRin     = ctl_q.mdr_in;
   assign MDRout    = ctl_q.mdr_out;
   assign IRin      = ctl_q.ir_in;
   assign Gra       = ctl_q.gra;
   assign Grb       = ctl_q.grb;
   assign Rout      = ctl_q.r_out;
   assign Rin       = ctl_q.r_in;
   assign BAout     = ctl_q.ba_out;
   assign RYin      = ctl_q.ry_in;
   assign Immout    = ctl_q.imm_out;
   assign RZin      = ctl_q.rz_in;
   assign RZLOout   = ctl_q.rzlo_out;
   assign aluStart  = alu_start_q;
   assign opSelect  = op_sel_q;
   assign step      = state_q;
   assign done      = done_q;
   assign fault     = fault_q;
   assign faultCode = fcode_q;

endmodule

// File: tb/tb_ldst_sequencer.sv
// Bench for ldst_sequencer: builds an expected per-cycle trace for each
// instruction from its handshake latencies, then replays the stimulus and
// compares every output cycle by cycle.
module tb_ldst_sequencer;

   localparam int unsigned WL      = 16;
   localparam logic [5:0]  ALU_ADD = 6'd4;

   localparam logic [16:0] M_PCOUT  = 17'h10000, M_INCPC  = 17'h08000;
   localparam logic [16:0] M_MARIN  = 17'h04000, M_READ   = 17'h02000;
   localparam logic [16:0] M_WRITE  = 17'h01000, M_MDRIN  = 17'h00800;
   localparam logic [16:0] M_MDROUT = 17'h00400, M_IRIN   = 17'h00200;
   localparam logic [16:0] M_GRA    = 17'h00100, M_GRB    = 17'h00080;
   localparam logic [16:0] M_ROUT   = 17'h00040, M_RIN    = 17'h00020;
   localparam logic [16:0] M_BAOUT  = 17'h00010, M_RYIN   = 17'h00008;
   localparam logic [16:0] M_IMMOUT = 17'h00004, M_RZIN   = 17'h00002;
   localparam logic [16:0] M_RZLO   = 17'h00001;

   logic        Clock = 1'b0, clear = 1'b0, run = 1'b0;
   logic        memFinished = 1'b0, aluFinished = 1'b0;
   logic [31:0] ir = '0;
   logic PCout, IncPC, MARin, Read, Write, MDRin, MDRout, IRin;
   logic Gra, Grb, Rout, Rin, BAout, RYin, Immout, RZin, RZLOout;
   logic       aluStart, done, fault;
   logic [5:0] opSelect;
   logic [3:0] step;
   logic [1:0] faultCode;

   always #5 Clock = ~Clock;

   ldst_sequencer #(.WAIT_LIMIT(WL)) dut (
      .Clock(Clock), .clear(clear), .run(run), .ir(ir),
      .memFinished(memFinished), .aluFinished(aluFinished),
      .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Read(Read), .Write(Write),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb),
      .Rout(Rout), .Rin(Rin), .BAout(BAout), .RYin(RYin), .Immout(Immout),
      .RZin(RZin), .RZLOout(RZLOout), .aluStart(aluStart), .opSelect(opSelect),
      .step(step), .done(done), .fault(fault), .faultCode(faultCode)
   );

   wire [16:0] dut_ctl = {PCout, IncPC, MARin, Read, Write, MDRin, MDRout, IRin,
                          Gra, Grb, Rout, Rin, BAout, RYin, Immout, RZin, RZLOout};

   typedef struct {
      logic [3:0]  step;
      logic [16:0] ctl;
      logic        astart;
      logic [5:0]  opsel;
      logic        done;
      logic        fault;
      logic [1:0]  fcode;
      logic        run;
      logic        mem;
      logic        alu;
      logic [31:0] ir;
   } row_t;

   row_t q[$];
   int   errors = 0;
   int   checks = 0;

   // Single comparison point: counts and reports
   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input row_t r);
      chk_eq({tag, " step"},      32'(step),      32'(r.step));
      chk_eq({tag, " ctl"},       32'(dut_ctl),   32'(r.ctl));
      chk_eq({tag, " aluStart"},  32'(aluStart),  32'(r.astart));
      chk_eq({tag, " opSelect"},  32'(opSelect),  32'(r.opsel));
      chk_eq({tag, " done"},      32'(done),      32'(r.done));
      chk_eq({tag, " fault"},     32'(fault),     32'(r.fault));
      chk_eq({tag, " faultCode"}, 32'(faultCode), 32'(r.fcode));
      chk_eq({tag, " bus1hot"},
             32'($countones({PCout, MDRout, Rout, RZLOout, Immout}) <= 1), 32'(1));
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic [3:0] st, input logic [16:0] ctl, input logic as,
                       input logic [5:0] os, input logic dn, input logic ft,
                       input logic [1:0] fc, input logic rn, input logic mf,
                       input logic af, input logic [31:0] irv);
      row_t r;
      r.step = st; r.ctl = ctl; r.astart = as; r.opsel = os; r.done = dn;
      r.fault = ft; r.fcode = fc; r.run = rn; r.mem = mf; r.alu = af; r.ir = irv;
      q.push_back(r);
   endtask

   task automatic push_idle(input logic rn);
      push(4'd0, '0, 1'b0, '0, 1'b0, 1'b0, 2'b00, rn, rb(), rb(), $urandom());
   endtask

   // FAULT is terminal; run and handshakes are random to show they are ignored
   task automatic push_fault(input logic [1:0] fc);
      repeat (4) push(4'd15, '0, 1'b0, '0, 1'b0, 1'b1, fc, rb(), rb(), rb(), $urandom());
   endtask

   // A stall state held until the handshake arrives on cycle lat (0-based)
   task automatic wait_rows(input logic [3:0] st, input logic [16:0] ctl, input logic [5:0] os,
                            input bit is_alu, input int lat, output bit timed_out);
      bit hs;
      timed_out = 1'b1;
      for (int c = 0; c < int'(WL); c++) begin
         hs = (c == lat);
         push(st, ctl, is_alu && (c == 0), os, 1'b0, 1'b0, 2'b00, rb(),
              is_alu ? rb() : hs, is_alu ? hs : rb(), $urandom());
         if (hs) begin
            timed_out = 1'b0;
            return;
         end
      end
   endtask

   // Whole-instruction expected trace: T0 through DONE (or FAULT)
   task automatic gen_instr(input logic [31:0] irv, input int lm1, input int la,
                            input int lm2, input logic run_next, output bit faulted);
      logic [4:0] opc;
      bit to;
      opc = irv[31:27];
      faulted = 1'b1;
      push(4'd1, M_INCPC, 1'b0, '0, 1'b0, 1'b0, 2'b00, rb(), rb(), rb(), $urandom());
      wait_rows(4'd2, M_PCOUT | M_MARIN | M_READ | M_MDRIN, '0, 1'b0, lm1, to);
      if (to) begin push_fault(2'b01); return; end
      push(4'd3, M_MDROUT | M_IRIN, 1'b0, '0, 1'b0, 1'b0, 2'b00, rb(), rb(), rb(), $urandom());
      push(4'd4, M_GRB | M_BAOUT | M_ROUT | M_RYIN, 1'b0, '0, 1'b0, 1'b0, 2'b00,
           rb(), rb(), rb(), irv);
      if (opc > 5'd2) begin push_fault(2'b11); return; end
      wait_rows(4'd5, M_IMMOUT | M_RZIN, ALU_ADD, 1'b1, la, to);
      if (to) begin push_fault(2'b10); return; end
      if (opc == 5'd1) begin
         push(4'd6, M_RZLO | M_GRA | M_RIN, 1'b0, ALU_ADD, 1'b0, 1'b0, 2'b00,
              rb(), rb(), rb(), $urandom());
      end else begin
         push(4'd6, M_RZLO | M_MARIN, 1'b0, ALU_ADD, 1'b0, 1'b0, 2'b00,
              rb(), rb(), rb(), $urandom());
         if (opc == 5'd0) begin
            wait_rows(4'd7, M_READ | M_MDRIN, '0, 1'b0, lm2, to);
            if (to) begin push_fault(2'b01); return; end
            push(4'd8, M_MDROUT | M_GRA | M_RIN, 1'b0, '0, 1'b0, 1'b0, 2'b00,
                 rb(), rb(), rb(), $urandom());
         end else begin
            push(4'd7, M_GRA | M_ROUT | M_MDRIN, 1'b0, '0, 1'b0, 1'b0, 2'b00,
                 rb(), rb(), rb(), $urandom());
            wait_rows(4'd8, M_WRITE, '0, 1'b0, lm2, to);
            if (to) begin push_fault(2'b01); return; end
         end
      end
      push(4'd9, '0, 1'b0, '0, 1'b1, 1'b0, 2'b00, run_next, rb(), rb(), $urandom());
      faulted = 1'b0;
   endtask

   task automatic start_session();
      q.delete();
      repeat ($urandom_range(0, 2)) push_idle(1'b0);
      push_idle(1'b1);
   endtask

   // Reset, then replay rows 0..stop_row (all rows if stop_row < 0)
   task automatic run_session(input string name, input int stop_row);
      row_t z;
      int   n;
      int   e0;
      z = '{default: '0};
      n = q.size();
      if (stop_row >= 0 && stop_row < n) n = stop_row + 1;
      @(negedge Clock);
      clear = 1'b0; run = 1'b0; memFinished = 1'b0; aluFinished = 1'b0;
      @(negedge Clock);
      chk_all({name, " rst"}, z);
      clear = 1'b1;
      for (int i = 0; i < n; i++) begin
         e0 = errors;
         if (i > 0) @(negedge Clock);
         chk_all($sformatf("%s r%0d", name, i), q[i]);
         run = q[i].run; memFinished = q[i].mem; aluFinished = q[i].alu; ir = q[i].ir;
         if (errors != e0) break;
      end
   endtask

   function automatic int rnd_lat();
      int r;
      r = int'($urandom_range(0, 39));
      if (r < 32) return int'($urandom_range(0, 3));
      if (r < 39) return int'($urandom_range(WL - 2, WL - 1));
      return int'(WL);
   endfunction

   function automatic logic [31:0] rnd_ir();
      int r;
      logic [4:0] opc;
      r = int'($urandom_range(0, 15));
      if (r < 5)       opc = 5'd0;
      else if (r < 10) opc = 5'd1;
      else if (r < 15) opc = 5'd2;
      else             opc = 5'($urandom_range(3, 31));
      return {opc, 27'($urandom())};
   endfunction

   initial begin
      bit   f;
      int   idx;
      int   ni;
      row_t z;
      row_t t0;
      z = '{default: '0};

      // st back-to-back with ldi, then idle
      start_session();
      gen_instr(32'h1080_0025, 2, 1, 2, 1'b1, f);
      gen_instr({5'd1, 27'($urandom())}, 1, 0, 0, 1'b0, f);
      push_idle(1'b0); push_idle(1'b0);
      run_session("st", -1);

      // ld with run low at DONE -> IDLE
      start_session();
      gen_instr({5'd0, 27'($urandom())}, 1, 2, 3, 1'b0, f);
      push_idle(1'b0); push_idle(1'b0);
      run_session("ld", -1);

      // ldi alone
      start_session();
      gen_instr({5'd1, 27'($urandom())}, 0, 3, 0, 1'b0, f);
      push_idle(1'b0);
      run_session("ldi", -1);

      // illegal opcode
      start_session();
      gen_instr({5'b11111, 27'($urandom())}, 0, 0, 0, 1'b0, f);
      run_session("illegal", -1);

      // fetch stall: timeout vs handshake on the last allowed cycle
      start_session();
      gen_instr({5'd0, 27'($urandom())}, int'(WL), 0, 0, 1'b0, f);
      run_session("t1_timeout", -1);
      start_session();
      gen_instr({5'd0, 27'($urandom())}, int'(WL) - 1, 0, 0, 1'b0, f);
      push_idle(1'b0);
      run_session("t1_last", -1);

      // ALU stall timeout and st write timeout
      start_session();
      gen_instr({5'd2, 27'($urandom())}, 0, int'(WL), 0, 1'b0, f);
      run_session("alu_timeout", -1);
      start_session();
      gen_instr({5'd2, 27'($urandom())}, 0, 0, int'(WL), 1'b0, f);
      run_session("st_timeout", -1);

      // reset asserted mid-T4
      start_session();
      gen_instr({5'd2, 27'($urandom())}, 0, 10, 0, 1'b0, f);
      idx = -1;
      foreach (q[i]) if (idx < 0 && q[i].step == 4'd5) idx = i;
      run_session("abort", idx + 2);
      #2 clear = 1'b0;
      #1 chk_all("abort async", z);
      @(negedge Clock);
      clear = 1'b1; run = 1'b1;
      @(negedge Clock);
      t0 = z; t0.step = 4'd1; t0.ctl = M_INCPC;
      chk_all("abort restart", t0);

      // randomized sessions
      for (int s = 0; s < 40; s++) begin
         start_session();
         ni = int'($urandom_range(1, 6));
         for (int k = 0; k < ni; k++) begin
            gen_instr(rnd_ir(), rnd_lat(), rnd_lat(), rnd_lat(), 1'(k != ni - 1), f);
            if (f) break;
         end
         if (!f) begin push_idle(1'b0); push_idle(1'b0); end
         run_session($sformatf("rnd%0d", s), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
